// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared types and constants for the one-hot round-robin arbiter.
// Exposes the default requester count, index width and arbiter state type.
package arb_pkg;

    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = $clog2(ARB_N);

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// req/rel flow into the arbiter; grant/grant_en/busy flow out of it.
interface onehot_rr_arbiter_if #(
    parameter int N = 8
);

    logic [N-1:0] req;
    logic         rel;
    logic [N-1:0] grant;
    logic         grant_en;
    logic         busy;

    modport slave (
        input  req,
        input  rel,
        output grant,
        output grant_en,
        output busy
    );

    modport master (
        output req,
        output rel,
        input  grant,
        input  grant_en,
        input  busy
    );

endinterface

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of (req & ~mask) from ptr.
// Ports: req_i, mask_i, ptr_i in; hit_o, sel_onehot_o, sel_idx_o out.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = ARB_N,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             hit_o,
    output logic [N-1:0]     sel_onehot_o,
    output logic [IDX_W-1:0] sel_idx_o
);

    logic [N-1:0]   cand;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W-1:0] rot_idx;
    logic [IDX_W:0]   sum;

    always_comb begin
        cand = req_i & ~mask_i;
        // rot[j] = cand[(j + ptr) mod N], so bit 0 is the top-priority slot
        dbl  = {cand, cand} >> ptr_i;
        rot  = dbl[N-1:0];
        hit_o = |rot;
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) rot_idx = IDX_W'(i);
        end
        sum = {1'b0, rot_idx} + {1'b0, ptr_i};
        if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
        sel_idx_o = sum[IDX_W-1:0];
        sel_onehot_o = hit_o ? (N'(1) << sel_idx_o) : '0;
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and enable strobe.
// Ports: clk, rst (async high); bus (slave): req, rel in; grant, grant_en, busy out.
module onehot_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    onehot_rr_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(N);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] own_q, own_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [N-1:0]     grant_q, grant_d;

    logic [IDX_W-1:0] nxt_ptr;
    logic [IDX_W-1:0] srch_ptr;
    logic [N-1:0]     mask;
    logic             in_grant;
    logic             timeout;
    logic             end_c;
    logic             hit;
    logic [N-1:0]     sel_oh;
    logic [IDX_W-1:0] sel_idx;

    assign in_grant = (state_q == ARB_GRANT);
    assign nxt_ptr  = (own_q == IDX_W'(N - 1)) ? '0 : own_q + 1'b1;
    assign timeout  = (HOLD_MAX != 0) && (hold_q == CNT_W'(HOLD_MAX));
    assign end_c    = bus.rel | ~bus.req[own_q] | timeout;

    // In GRANT the search starts past the owner and excludes it, so a
    // released or timed-out owner can never be regranted on the same edge.
    assign srch_ptr = in_grant ? nxt_ptr : ptr_q;
    assign mask     = in_grant ? grant_q : '0;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i        (bus.req),
        .mask_i       (mask),
        .ptr_i        (srch_ptr),
        .hit_o        (hit),
        .sel_onehot_o (sel_oh),
        .sel_idx_o    (sel_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (hit) begin
                    state_d = ARB_GRANT;
                    grant_d = sel_oh;
                    own_d   = sel_idx;
                    hold_d  = CNT_W'(1);
                end
            end
            ARB_GRANT: begin
                if (!end_c) begin
                    if (hold_q != '1) hold_d = hold_q + 1'b1;
                end else begin
                    ptr_d = nxt_ptr;
                    if (hit) begin
                        grant_d = sel_oh;
                        own_d   = sel_idx;
                        hold_d  = CNT_W'(1);
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        hold_d  = '0;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_en = in_grant;
    assign bus.busy     = in_grant;

endmodule
